// File: rtl/csl_pkg.sv
// Shared types and helpers for the segmented carry-select adder sequencer.
// Optional early exit in csl_seq_ctrl is enabled by defining CSL_EARLY_EXIT_EN.
package csl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MAX_W = 64;

    // Index width for n entries, never below one bit.
    function automatic int seg_idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic logic [MAX_W-1:0] seg_slice(
        input logic [MAX_W-1:0] v,
        input int               idx,
        input int               seg_w
    );
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - seg_w);
        return (v >> (idx * seg_w)) & mask;
    endfunction

endpackage

// File: rtl/csl_seg_add.sv
// Dual-rail segment adder: forms the cin=0 and cin=1 sums in parallel,
// then the group carry picks one.
module csl_seg_add #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             sel,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    logic [SEG_W:0] s0;
    logic [SEG_W:0] s1;
    logic [SEG_W:0] pick;

    assign s0   = {1'b0, a} + {1'b0, b};
    assign s1   = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, 1'b1};
    assign pick = sel ? s1 : s0;

    assign {cout, sum} = pick;

endmodule

// File: rtl/csl_seq_ctrl.sv
// Sequencer adding one SEG_W segment per cycle, LSB first, using one shared
// carry-select segment adder. Define CSL_EARLY_EXIT_EN for zero-tail early exit.
module csl_seq_ctrl
    import csl_pkg::*;
#(
    parameter int W     = 16,
    parameter int SEG_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy,
    output logic         seg_sel
);

    localparam int NSEG = W / SEG_W;
    localparam int IW   = seg_idx_w(NSEG);
    localparam int BW   = seg_idx_w(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSEG - 1);

    generate
        if (SEG_W < 1 || W > MAX_W || (W % SEG_W) != 0) begin : g_bad_cfg
            $error("csl_seq_ctrl: W must be a nonzero multiple of SEG_W");
        end
    endgenerate

    state_t          state;
    state_t          state_n;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    result_r;
    logic            carry_r;
    logic            cout_r;
    logic [IW-1:0]   seg_idx;
    logic [BW-1:0]   seg_base;

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;
    logic [MAX_W-1:0] a_sl;
    logic [MAX_W-1:0] b_sl;
    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_cout;
    logic             last_seg;
    logic             early;

    assign seg_base = BW'(32'(seg_idx) * 32'(SEG_W));
    assign last_seg = (seg_idx == LAST_IDX);

    always_comb begin
        a_ext          = '0;
        b_ext          = '0;
        a_ext[W-1:0]   = a_r;
        b_ext[W-1:0]   = b_r;
        a_sl           = seg_slice(a_ext, int'(seg_idx), SEG_W);
        b_sl           = seg_slice(b_ext, int'(seg_idx), SEG_W);
        seg_a          = a_sl[SEG_W-1:0];
        seg_b          = b_sl[SEG_W-1:0];
    end

    csl_seg_add #(
        .SEG_W (SEG_W)
    ) u_seg_add (
        .a    (seg_a),
        .b    (seg_b),
        .sel  (carry_r),
        .sum  (seg_sum),
        .cout (seg_cout)
    );

`ifdef CSL_EARLY_EXIT_EN
    // Remaining operand segments all zero: only the pending carry is left.
    assign early = ((a_r >> seg_base) == '0) && ((b_r >> seg_base) == '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (early || last_seg) state_n = DONE;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
            seg_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        carry_r <= in_cin;
                        seg_idx <= '0;
                    end
                end
                RUN: begin
                    if (early) begin
                        result_r <= (result_r & ~({W{1'b1}} << seg_base))
                                  | (W'(carry_r) << seg_base);
                        cout_r   <= 1'b0;
                    end else begin
                        result_r[seg_base +: SEG_W] <= seg_sum;
                        carry_r                     <= seg_cout;
                        if (last_seg) begin
                            cout_r <= seg_cout;
                        end else begin
                            seg_idx <= seg_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign seg_sel   = (state == RUN) && carry_r;
    assign out_sum   = result_r;
    assign out_cout  = cout_r;

endmodule

// File: tb/tb_csl_seq_ctrl.sv
// Directed self-checking bench for csl_seq_ctrl (W=16, SEG_W=4).
// Expected latencies follow CSL_EARLY_EXIT_EN when it is defined.
module tb_csl_seq_ctrl;

    localparam int W     = 16;
    localparam int SEG_W = 4;

`ifdef CSL_EARLY_EXIT_EN
    localparam int LAT_00FF  = 3;
    localparam int LAT_SMALL = 2;
    localparam int LAT_ZERO  = 1;
`else
    localparam int LAT_00FF  = 4;
    localparam int LAT_SMALL = 4;
    localparam int LAT_ZERO  = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          busy;
    logic          seg_sel;

    int total  = 0;
    int passed = 0;

    csl_seq_ctrl #(
        .W     (W),
        .SEG_W (SEG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy),
        .seg_sel   (seg_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand, wait for it to be taken, then count cycles to out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, output int lat,
                          output logic [3:0] sels);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        else
            passed++;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat  = 0;
        sels = '0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) sels[lat] = seg_sel;
            step();
            lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid);
        else passed++;
        total++;
        if (out_sum !== 16'h0000) $display("FAIL rst_sum: got %h want 0000", out_sum);
        else passed++;
        total++;
        if (out_cout !== 1'b0) $display("FAIL rst_cout: got %b want 0", out_cout);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (seg_sel !== 1'b0) $display("FAIL rst_sel: got %b want 0", seg_sel);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        logic [3:0] sels;
        run_op(16'h00FF, 16'h0001, 1'b0, lat, sels);
        total++;
        if (lat != LAT_00FF) $display("FAIL t1_latency: got %0d want %0d", lat, LAT_00FF);
        else passed++;
        total++;
        if (out_sum !== 16'h0100) $display("FAIL t1_sum: got %h want 0100", out_sum);
        else passed++;
        total++;
        if (out_cout !== 1'b0) $display("FAIL t1_cout: got %b want 0", out_cout);
        else passed++;
        ack();
        total++;
        if (out_valid !== 1'b0) $display("FAIL t1_valid_drop: got %b want 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL t1_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_carry_chain();
        int lat;
        logic [3:0] sels;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, sels);
        total++;
        if (lat != 4) $display("FAIL t2_latency: got %0d want 4", lat);
        else passed++;
        total++;
        if (out_sum !== 16'h0000) $display("FAIL t2_sum: got %h want 0000", out_sum);
        else passed++;
        total++;
        if (out_cout !== 1'b1) $display("FAIL t2_cout: got %b want 1", out_cout);
        else passed++;
        total++;
        if (sels !== 4'b1110) $display("FAIL t2_seg_sel: got %b want 1110", sels);
        else passed++;
        ack();
    endtask

    task automatic test_all_ones();
        int lat;
        logic [3:0] sels;
        run_op(16'hFFFF, 16'hFFFF, 1'b1, lat, sels);
        total++;
        if (out_sum !== 16'hFFFF) $display("FAIL t3_sum: got %h want FFFF", out_sum);
        else passed++;
        total++;
        if (out_cout !== 1'b1) $display("FAIL t3_cout: got %b want 1", out_cout);
        else passed++;
        total++;
        if (sels !== 4'b1111) $display("FAIL t3_seg_sel: got %b want 1111", sels);
        else passed++;
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] sels;
        run_op(16'h1234, 16'h0F0F, 1'b0, lat, sels);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1) $display("FAIL t4_hold_valid: cyc %0d got %b want 1", i, out_valid);
            else passed++;
            total++;
            if (out_sum !== 16'h2143) $display("FAIL t4_hold_sum: cyc %0d got %h want 2143", i, out_sum);
            else passed++;
            total++;
            if (out_cout !== 1'b0) $display("FAIL t4_hold_cout: cyc %0d got %b want 0", i, out_cout);
            else passed++;
            total++;
            if (in_ready !== 1'b0) $display("FAIL t4_hold_ready: cyc %0d got %b want 0", i, in_ready);
            else passed++;
            step();
        end
        ack();
        total++;
        if (out_valid !== 1'b0) $display("FAIL t4_release_valid: got %b want 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL t4_release_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [3:0] sels;
        in_a     = 16'h08F9;
        in_b     = 16'h0009;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        total++;
        if (seg_sel !== 1'b1) $display("FAIL t5_pre_sel: got %b want 1", seg_sel);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (out_sum !== 16'h0000) $display("FAIL t5_abort_sum: got %h want 0000", out_sum);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL t5_abort_busy: got %b want 0", busy);
        else passed++;
        total++;
        if (seg_sel !== 1'b0) $display("FAIL t5_abort_sel: got %b want 0", seg_sel);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || out_cout !== 1'b0)
            $display("FAIL t5_abort_out: valid=%b cout=%b want 0 0", out_valid, out_cout);
        else passed++;
        step();
        rst = 1'b0;
        step();
        run_op(16'h1234, 16'h4321, 1'b0, lat, sels);
        total++;
        if (lat != 4) $display("FAIL t5_latency: got %0d want 4", lat);
        else passed++;
        total++;
        if (out_sum !== 16'h5555) $display("FAIL t5_sum: got %h want 5555", out_sum);
        else passed++;
        total++;
        if (out_cout !== 1'b0) $display("FAIL t5_cout: got %b want 0", out_cout);
        else passed++;
        ack();
    endtask

    task automatic test_early_exit();
        int lat;
        logic [3:0] sels;
        run_op(16'h0003, 16'h0001, 1'b0, lat, sels);
        total++;
        if (lat != LAT_SMALL) $display("FAIL t6_latency: got %0d want %0d", lat, LAT_SMALL);
        else passed++;
        total++;
        if (out_sum !== 16'h0004) $display("FAIL t6_sum: got %h want 0004", out_sum);
        else passed++;
        ack();
        run_op(16'h0000, 16'h0000, 1'b1, lat, sels);
        total++;
        if (lat != LAT_ZERO) $display("FAIL t6_zero_latency: got %0d want %0d", lat, LAT_ZERO);
        else passed++;
        total++;
        if (out_sum !== 16'h0001) $display("FAIL t6_zero_sum: got %h want 0001", out_sum);
        else passed++;
        total++;
        if (out_cout !== 1'b0) $display("FAIL t6_zero_cout: got %b want 0", out_cout);
        else passed++;
        ack();
    endtask

    task automatic test_back_to_back();
        int cnt;
        int n;
        logic [15:0] got;
        got       = '0;
        in_a      = 16'h1111;
        in_b      = 16'h2222;
        in_cin    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        // Operand changes while busy must not disturb the op in flight.
        in_a = 16'hABCD;
        in_b = 16'h1234;
        cnt  = 1;
        while (!in_ready && cnt < 20) begin
            if (out_valid) got = out_sum;
            step();
            cnt++;
        end
        total++;
        if (cnt != 6) $display("FAIL b2b_interval: got %0d want 6", cnt);
        else passed++;
        total++;
        if (got !== 16'h3333) $display("FAIL b2b_first_sum: got %h want 3333", got);
        else passed++;
        step();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_second_accept: busy=%b want 1", busy);
        else passed++;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n != 4) $display("FAIL b2b_second_latency: got %0d want 4", n);
        else passed++;
        total++;
        if (out_sum !== 16'hBE01) $display("FAIL b2b_second_sum: got %h want BE01", out_sum);
        else passed++;
        step();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_idle: in_ready=%b want 1", in_ready);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_all_ones();
        test_backpressure();
        test_reset_abort();
        test_early_exit();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
